// File: rtl/count_pkg.sv
// +----------------------------------------------------------------------------+
// | count_pkg : shared direction/mode enums and widths for count_mod_updown    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package count_pkg;

    typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;
    typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;

    localparam int WRAPCNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/count_next_calc.sv
// +----------------------------------------------------------------------------+
// | count_next_calc : combinational next count and boundary-hit for one step   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module count_next_calc
    import count_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] cur,
    input  cnt_dir_e         dir,
    input  cnt_mode_e        mode,
    output logic [WIDTH-1:0] nxt,
    output logic             hit
);

    localparam logic [WIDTH:0] C_ONE     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] C_MAX_EXT = {1'b0, MOD_MAX};

    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;

    // One extra bit: an increment past MOD_MAX or a borrow below zero shows up
    // there instead of aliasing back into the visible count.
    always_comb begin
        inc_ext = {1'b0, cur} + C_ONE;
        dec_ext = {1'b0, cur} - C_ONE;
        hit     = 1'b0;
        nxt     = cur;
        if (dir == CNT_UP) begin
            hit = (inc_ext > C_MAX_EXT);
            if (hit) begin
                nxt = (mode == CNT_SAT) ? MOD_MAX : '0;
            end else begin
                nxt = inc_ext[WIDTH-1:0];
            end
        end else begin
            hit = dec_ext[WIDTH];
            if (hit) begin
                nxt = (mode == CNT_SAT) ? '0 : MOD_MAX;
            end else begin
                nxt = dec_ext[WIDTH-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_mod_updown.sv
// +----------------------------------------------------------------------------+
// | count_mod_updown : modulo up/down counter, load, wrap/saturate, tc pulse   |
// | Optional macro COUNT_WRAPCNT_EN adds the saturating wrap_cnt output.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module count_mod_updown
    import count_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up_down,
    input  logic                 load,
    input  logic [WIDTH-1:0]     cin,
    input  logic                 sat_mode,
    output logic [WIDTH-1:0]     cout,
    output logic                 at_max,
    output logic                 at_zero,
    output logic                 tc
`ifdef COUNT_WRAPCNT_EN
    ,
    output logic [WRAPCNT_W-1:0] wrap_cnt
`endif
);

    logic [WIDTH-1:0] cout_d, cout_q;
    logic             tc_d, tc_q;
    logic [WIDTH-1:0] step_nxt;
    logic             step_hit;
    logic [WIDTH-1:0] load_val;
    cnt_dir_e         dir;
    cnt_mode_e        mode;

    assign dir  = cnt_dir_e'(up_down);
    assign mode = cnt_mode_e'(sat_mode);

    count_next_calc #(
        .WIDTH   (WIDTH),
        .MOD_MAX (MOD_MAX)
    ) u_next (
        .cur  (cout_q),
        .dir  (dir),
        .mode (mode),
        .nxt  (step_nxt),
        .hit  (step_hit)
    );

    assign load_val = (cin > MOD_MAX) ? MOD_MAX : cin;

    always_comb begin
        cout_d = cout_q;
        tc_d   = 1'b0;
        if (load) begin
            cout_d = load_val;
        end else if (en) begin
            cout_d = step_nxt;
            tc_d   = step_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cout_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            cout_q <= cout_d;
            tc_q   <= tc_d;
        end
    end

    assign cout    = cout_q;
    assign tc      = tc_q;
    assign at_max  = (cout_q == MOD_MAX);
    assign at_zero = (cout_q == '0);

`ifdef COUNT_WRAPCNT_EN
    logic [WRAPCNT_W-1:0] wrap_cnt_d, wrap_cnt_q;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (load) begin
            wrap_cnt_d = '0;
        end else if (tc_d && (wrap_cnt_q != {WRAPCNT_W{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_mod_updown.sv
// +----------------------------------------------------------------------------+
// | tb_count_mod_updown : self-checking bench for count_mod_updown             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_count_mod_updown;

    localparam int MOD = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up_down = 1'b1, load = 1'b0, sat_mode = 1'b0;
    logic [3:0] cin = '0;
    logic [3:0] cout;
    logic       at_max, at_zero, tc;

    logic       rst8 = 1'b0;
    logic       en8 = 1'b0, load8 = 1'b0;
    logic [7:0] cin8 = '0;
    logic [7:0] cout8;
    logic       at_max8, at_zero8, tc8;

`ifdef COUNT_WRAPCNT_EN
    logic [7:0] wrap_cnt, wrap_cnt8;
`endif

    always #5 clk = ~clk;

    count_mod_updown #(.WIDTH(4), .MOD_MAX(4'd9)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .cin(cin), .sat_mode(sat_mode), .cout(cout), .at_max(at_max),
        .at_zero(at_zero), .tc(tc)
`ifdef COUNT_WRAPCNT_EN
        , .wrap_cnt(wrap_cnt)
`endif
    );

    count_mod_updown #(.WIDTH(8), .MOD_MAX(8'd255)) u_dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up_down(1'b1), .load(load8),
        .cin(cin8), .sat_mode(1'b0), .cout(cout8), .at_max(at_max8),
        .at_zero(at_zero8), .tc(tc8)
`ifdef COUNT_WRAPCNT_EN
        , .wrap_cnt(wrap_cnt8)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: count as an integer on the ring 0..MOD
    int m_cnt = 0;
    int m_tc  = 0;
    int m_wc  = 0;

    typedef struct {
        logic       ld;
        logic       e;
        logic       u;
        logic       s;
        logic [3:0] c;
        int         exp_cout;
        int         exp_tc;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_tc  = 0;
        m_wc  = 0;
    endtask

    task automatic model_step(input logic ld, input logic e, input logic u,
                              input logic s, input int c);
        int at_bound;
        if (ld) begin
            m_cnt = (c > MOD) ? MOD : c;
            m_tc  = 0;
            m_wc  = 0;
        end else if (e) begin
            at_bound = u ? (m_cnt == MOD) : (m_cnt == 0);
            m_tc = at_bound;
            if (u) m_cnt = (at_bound && s) ? MOD : (m_cnt + 1) % (MOD + 1);
            else   m_cnt = (at_bound && s) ? 0   : (m_cnt + MOD) % (MOD + 1);
            if (m_tc == 1 && m_wc < 255) m_wc = m_wc + 1;
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic check_model(input string name);
        chk({name, ".cout"}, int'(cout), m_cnt);
        chk({name, ".tc"}, int'(tc), m_tc);
        chk({name, ".at_max"}, int'(at_max), int'(m_cnt == MOD));
        chk({name, ".at_zero"}, int'(at_zero), int'(m_cnt == 0));
`ifdef COUNT_WRAPCNT_EN
        chk({name, ".wrap_cnt"}, int'(wrap_cnt), m_wc);
`endif
    endtask

    task automatic cyc(input logic ld, input logic e, input logic u,
                       input logic s, input logic [3:0] c, input string name);
        load = ld; en = e; up_down = u; sat_mode = s; cin = c;
        @(posedge clk);
        model_step(ld, e, u, s, int'(c));
        #1;
        check_model(name);
    endtask

    initial begin
        // ld, en, up, sat, cin, cout, tc
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 9, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 0, 1};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 9, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 5, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 5, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 0, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 0, 1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1, 0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 9, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 9, 1};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 0, 1};

        // Reset held with en high: count must stay cleared
        rst = 1'b0; en = 1'b1; up_down = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst.cout", int'(cout), 0);
            chk("rst.tc", int'(tc), 0);
            chk("rst.at_zero", int'(at_zero), 1);
            chk("rst.at_max", int'(at_max), 0);
        end
        rst = 1'b1;

        // Up 12 cycles in wrap mode: 1..9, 0, 1, 2 with tc after 9->0
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, "up12");
            chk("up12.seq", int'(cout), (i + 1) % 10);
            chk("up12.tc", int'(tc), (i == 9) ? 1 : 0);
        end

        // Table vectors
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].ld, tbl[i].e, tbl[i].u, tbl[i].s, tbl[i].c, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.cout", i), int'(cout), tbl[i].exp_cout);
            chk($sformatf("tbl%0d.tc", i), int'(tc), tbl[i].exp_tc);
        end

        // Hold at 6 then alternate direction
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h6, "ld6");
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, "hold");
            chk("hold.cout", int'(cout), 6);
            chk("hold.tc", int'(tc), 0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, (i % 2 == 0), 1'b0, 4'h0, "toggle");
            chk("toggle.cout", int'(cout), (i % 2 == 0) ? 7 : 6);
        end

        // Sat-mode descent from 2
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h2, "ld2");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, "satdn");
            chk("satdn.cout", int'(cout), (i == 0) ? 1 : 0);
            chk("satdn.tc", int'(tc), (i >= 2) ? 1 : 0);
        end

        // Asynchronous reset between edges at count 7
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h7, "ld7");
        load = 1'b0; en = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async.cout", int'(cout), 0);
        chk("async.at_zero", int'(at_zero), 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

`ifdef COUNT_WRAPCNT_EN
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, "wc.ld0");
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, "wc.up");
        chk("wc.three", int'(wrap_cnt), 3);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'h9, "wc.ld9");
        chk("wc.clr", int'(wrap_cnt), 0);
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, "wc.sat");
        chk("wc.sat255", int'(wrap_cnt), 255);
`endif

        // Randomised run against the model
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(7) == 0), ($urandom_range(3) != 0), 1'($urandom),
                1'($urandom), 4'($urandom_range(15)), "rand");
        end

        // 8-bit full-range instance: 254 -> 255 -> 0 (tc) -> 1
        rst8 = 1'b1;
        load8 = 1'b1; cin8 = 8'd254;
        @(posedge clk); #1;
        chk("w8.ld", int'(cout8), 254);
        load8 = 1'b0; en8 = 1'b1;
        @(posedge clk); #1;
        chk("w8.c255", int'(cout8), 255);
        chk("w8.max", int'(at_max8), 1);
        chk("w8.tc0", int'(tc8), 0);
        @(posedge clk); #1;
        chk("w8.c0", int'(cout8), 0);
        chk("w8.tc1", int'(tc8), 1);
        chk("w8.zero", int'(at_zero8), 1);
        @(posedge clk); #1;
        chk("w8.c1", int'(cout8), 1);
        chk("w8.tc2", int'(tc8), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
